// File: rtl/simd_pkg.sv
// Shared constants and vector types for the SIMD sample path.
package simd_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 8;
  localparam int VEC_W  = LANES * LANE_W;
  localparam int CNT_W  = $clog2(LANES) + 1;
  localparam int IDX_W  = $clog2(LANES);

  typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;
  typedef logic [VEC_W-1:0]             vec_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } asm_state_t;

endpackage

// File: rtl/lanes2vec.sv
// Combinational flatten of a lane array into a flat vector; lane i lands
// at bits [i*LANE_W +: LANE_W], the inverse of the vector-to-lane unpacker.
module lanes2vec
  import simd_pkg::*;
(
  input  lanes_t i_lanes,
  output vec_t   o_vec
);

  // Place each lane at its fixed bit slice.
  always_comb begin
    o_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      o_vec[i*LANE_W +: LANE_W] = i_lanes[i];
    end
  end

endmodule

// File: rtl/sample_vec_packer.sv
// Byte-to-vector packer: collects samples into a 16-lane assembly register,
// then hands the finished (or flushed, zero-padded) vector to an independent
// output register. Assembly + output register give two-deep buffering.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_FILL | accepting samples; asm_cnt < LANES and no flush pending
// ST_HOLD | assembly complete or flushed; waiting for output register
module sample_vec_packer
  import simd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LANE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [VEC_W-1:0]  out_data,
  output logic [4:0]        out_lanes,
  output logic              out_valid,
  input  logic              out_ready
);

  asm_state_t        r_state;
  asm_state_t        w_state_nxt;
  lanes_t            r_asm_data;
  logic [CNT_W-1:0]  r_asm_cnt;
  logic              r_flush_pend;
  vec_t              r_out_data;
  logic [4:0]        r_out_lanes;
  logic              r_out_valid;

  vec_t              w_asm_vec;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_flush_set;
  logic              w_xfer;

  lanes2vec u_lanes2vec (
    .i_lanes (r_asm_data),
    .o_vec   (w_asm_vec)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake qualifiers and flush capture.
  always_comb begin
    w_state_nxt = r_state;
    w_flush_set = 1'b0;
    w_xfer      = 1'b0;
    w_in_ready  = (r_asm_cnt < CNT_W'(LANES)) && !r_flush_pend;
    w_accept    = in_valid && w_in_ready;
    case (r_state)
      ST_FILL: begin
        // A flush counts if anything is assembled, including this cycle's sample.
        if (flush && ((r_asm_cnt != '0) || w_accept)) begin
          w_flush_set = 1'b1;
        end
        if (w_flush_set || (w_accept && (r_asm_cnt == CNT_W'(LANES - 1)))) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Flush in HOLD is absorbed; only the output register gates progress.
        if (!r_out_valid || out_ready) begin
          w_xfer      = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // Assembly register: lane write on accept, cleared on transfer so later
  // partial vectors come out zero-padded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm_data   <= '0;
      r_asm_cnt    <= '0;
      r_flush_pend <= 1'b0;
    end else if (w_xfer) begin
      r_asm_data   <= '0;
      r_asm_cnt    <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_asm_data[r_asm_cnt[IDX_W-1:0]] <= in_data;
        r_asm_cnt                        <= r_asm_cnt + CNT_W'(1);
      end
      if (w_flush_set) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  // Output register: loads on transfer, holds steady until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_lanes <= '0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_data  <= w_asm_vec;
      r_out_lanes <= r_asm_cnt;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_lanes = r_out_lanes;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sample_vec_packer.sv
// Scoreboard bench for sample_vec_packer: the driver models the assembly
// and queues expected vectors; a negedge monitor pops and compares them.
module tb_sample_vec_packer;
  import simd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  vec_t        out_data;
  logic [4:0]  out_lanes;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [4:0] lanes;
    vec_t       data;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mq[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_vec = 0;
  int          v0;

  sample_vec_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_lanes (out_lanes),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void emit();
    exp_t e;
    e.data = '0;
    for (int i = 0; i < mq.size(); i++) e.data[i*8 +: 8] = mq[i];
    e.lanes = 5'(mq.size());
    sb.push_back(e);
    mq.delete();
  endfunction

  // Consumed vectors are compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        chk("unexpected_vec", {27'd0, out_lanes, out_data}, 160'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("vec_data", out_data, mon_e.data);
        chk("vec_lanes", out_lanes, mon_e.lanes);
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit fl);
    int tries = 0;
    bit done  = 0;
    in_data  = d;
    in_valid = 1'b1;
    flush    = fl;
    while (!done && tries < 500) begin
      @(negedge clk);
      if (in_ready) begin
        mq.push_back(d);
        n_acc++;
        done = 1;
      end
      if (mq.size() == 16 || (flush && in_ready && mq.size() > 0)) emit();
      @(posedge clk); #1;
      flush = 1'b0;
      tries++;
    end
    in_valid = 1'b0;
    chk("send_timeout", done, 1);
  endtask

  task automatic pulse_flush();
    flush    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    if (in_ready && mq.size() > 0) emit();
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lanes", out_lanes, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Full vector and latency.
    for (int i = 1; i <= 16; i++) send(8'(i), 0);
    @(negedge clk);
    chk("lat_t1_valid", out_valid, 0);
    chk("hold_in_ready", in_ready, 0);
    @(negedge clk);
    chk("lat_t2_valid", out_valid, 1);
    chk("full_vec", out_data, 128'h100F0E0D0C0B0A090807060504030201);
    @(negedge clk);
    chk("lat_t3_valid", out_valid, 0);
    @(posedge clk); #1;

    // Backpressure.
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(8'(i), 0);
        pulse_flush();
      end
      begin
        int t = 0;
        while (n_acc < 32 && t < 2000) begin
          @(negedge clk);
          t++;
        end
        repeat (5) @(negedge clk);
        chk("bp_acc", n_acc, 32);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_data", out_data, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("bp_out_lanes", out_lanes, 16);
        @(negedge clk);
        chk("bp_stable", out_data, 128'h0F0E0D0C0B0A09080706050403020100);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(5);

    // Partial flush, then a fresh vector from lane 0.
    for (int i = 0; i < 5; i++) send(8'hA1 + 8'(i), 0);
    pulse_flush();
    @(negedge clk);
    @(negedge clk);
    chk("pf_valid", out_valid, 1);
    chk("pf_data", out_data, 128'h000000000000000000000000A5A4A3A2A1);
    chk("pf_lanes", out_lanes, 5);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i), 0);
    idle(5);

    // Flush with empty assembly.
    v0 = n_vec;
    pulse_flush();
    idle(10);
    chk("flush_empty_novec", n_vec, v0);

    // Flush on the 16th sample.
    v0 = n_vec;
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), i == 15);
    idle(10);
    chk("flush16_one_vec", n_vec, v0 + 1);

    // Reset mid-fill.
    for (int i = 0; i < 7; i++) send(8'h50 + 8'(i), 0);
    rst = 1'b1;
    mq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    v0 = n_vec;
    for (int i = 0; i < 16; i++) send(8'h60 + 8'(i), 0);
    idle(10);
    chk("rst_mid_one_vec", n_vec, v0 + 1);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
